// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS sweep sequencer and its dds_happen integration.
package dds_pkg;

    localparam int DDS_FW      = 32;
    localparam int DDS_PW      = 11;
    localparam int DDS_CW      = 16;
    localparam int DDS_LAT_DEF = 3;

    localparam int MODE_CONT = 0;
    localparam int MODE_TRI  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Per-step dwell down-counter: latches the dwell on load, pulses step_end on the last cycle
// of every step while running. A dwell of 0 behaves as 1.
module dds_dwell_timer
    import dds_pkg::*;
#(
    parameter int CW = DDS_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          run,
    input  logic [CW-1:0] dwell,
    output logic          step_end
);

    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] load_val;

    always_comb begin
        load_val = (dwell == '0) ? '0 : dwell - 1'b1;
        period_d = period_q;
        cnt_d    = cnt_q;
        if (load) begin
            period_d = load_val;
            cnt_d    = load_val;
        end else if (run) begin
            cnt_d = (cnt_q == '0) ? period_q : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= '0;
            cnt_q    <= '0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

    assign step_end = run && (cnt_q == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Stepped frequency sweep sequencer driving fword/pword/en of dds_happen.
//
//   state | meaning
//   IDLE  | DDS disabled, waiting for start
//   UP    | stepping k = 0..N, fword += f_step per step
//   DOWN  | triangle return leg, k = N-1..0, fword -= f_step per step
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int FW      = DDS_FW,
    parameter int PW      = DDS_PW,
    parameter int CW      = DDS_CW,
    parameter int DDS_LAT = DDS_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_step,
    input  logic [CW-1:0] n_steps,
    input  logic [CW-1:0] dwell,
    input  logic [PW-1:0] p_off,
    input  logic [1:0]    mode,
    output logic [FW-1:0] fword,
    output logic [PW-1:0] pword,
    output logic          dds_en,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    output logic [CW-1:0] step_idx
);

    localparam int LW = $clog2(DDS_LAT + 2);

    state_e        state_q, state_d;
    logic [FW-1:0] f_start_q, f_start_d;
    logic [FW-1:0] f_step_q, f_step_d;
    logic [FW-1:0] fword_q, fword_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] step_idx_q, step_idx_d;
    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] pword_q, pword_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          accept;
    logic          step_end;

    assign accept = (state_q == IDLE) && start && !abort;

    dds_dwell_timer #(.CW(CW)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .run      (busy_q),
        .dwell    (dwell),
        .step_end (step_end)
    );

    always_comb begin
        state_d    = state_q;
        f_start_d  = f_start_q;
        f_step_d   = f_step_q;
        fword_d    = fword_q;
        n_d        = n_q;
        step_idx_d = step_idx_q;
        mode_d     = mode_q;
        pword_d    = pword_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = UP;
                    f_start_d  = f_start;
                    f_step_d   = f_step;
                    n_d        = n_steps;
                    mode_d     = mode;
                    pword_d    = p_off;
                    fword_d    = f_start;
                    step_idx_d = '0;
                end
            end
            UP: begin
                if (step_end) begin
                    if (step_idx_q == n_q) begin
                        if (mode_q[MODE_TRI] && n_q != '0) begin
                            state_d    = DOWN;
                            step_idx_d = step_idx_q - 1'b1;
                            fword_d    = fword_q - f_step_q;
                        end else if (mode_q[MODE_CONT]) begin
                            // Reload from the latched start word so repeats never drift.
                            step_idx_d = '0;
                            fword_d    = f_start_q;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        step_idx_d = step_idx_q + 1'b1;
                        fword_d    = fword_q + f_step_q;
                    end
                end
            end
            DOWN: begin
                if (step_end) begin
                    if (step_idx_q == '0) begin
                        if (mode_q[MODE_CONT]) begin
                            // Step 0 was just played; the next leg starts at k=1.
                            state_d    = UP;
                            step_idx_d = {{(CW-1){1'b0}}, 1'b1};
                            fword_d    = f_start_q + f_step_q;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        step_idx_d = step_idx_q - 1'b1;
                        fword_d    = fword_q - f_step_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end

        busy_d  = (state_d != IDLE);
        lat_d   = busy_d ? ((lat_q == LW'(DDS_LAT)) ? lat_q : lat_q + 1'b1) : '0;
        valid_d = busy_d && (lat_q >= LW'(DDS_LAT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            f_start_q  <= '0;
            f_step_q   <= '0;
            fword_q    <= '0;
            n_q        <= '0;
            step_idx_q <= '0;
            mode_q     <= '0;
            pword_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            f_start_q  <= f_start_d;
            f_step_q   <= f_step_d;
            fword_q    <= fword_d;
            n_q        <= n_d;
            step_idx_q <= step_idx_d;
            mode_q     <= mode_d;
            pword_q    <= pword_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            lat_q      <= lat_d;
        end
    end

    assign fword     = fword_q;
    assign pword     = pword_q;
    assign dds_en    = busy_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign step_idx  = step_idx_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed vector table, hand sequences and random sweeps
// compared cycle by cycle against an index-based reference model.
module tb_dds_sweep_ctrl;

    localparam int FW  = 32;
    localparam int PW  = 11;
    localparam int CW  = 16;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort;
    logic [FW-1:0] f_start, f_step;
    logic [CW-1:0] n_steps, dwell;
    logic [PW-1:0] p_off;
    logic [1:0]    mode;
    logic [FW-1:0] fword;
    logic [PW-1:0] pword;
    logic          dds_en, busy, done, out_valid;
    logic [CW-1:0] step_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.FW(FW), .PW(PW), .CW(CW), .DDS_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_step    (f_step),
        .n_steps   (n_steps),
        .dwell     (dwell),
        .p_off     (p_off),
        .mode      (mode),
        .fword     (fword),
        .pword     (pword),
        .dds_en    (dds_en),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .step_idx  (step_idx)
    );

    typedef struct {
        logic [FW-1:0] f_start;
        logic [FW-1:0] f_step;
        logic [CW-1:0] n;
        logic [CW-1:0] dwell;
        logic [PW-1:0] p_off;
        logic [1:0]    mode;
        int            ncyc;
        int            abort_at;
        int            restart_at;
        int            exp_done_at;
    } vec_t;

    typedef struct {
        bit            busy;
        bit            done;
        bit            valid;
        logic [FW-1:0] fword;
        logic [CW-1:0] k;
    } exp_t;

    // Expected outputs in cycle t+i after a start sampled at edge t.
    function automatic exp_t model(vec_t v, int i);
        exp_t          e;
        int            d, n, s, ph, len, sp, k;
        bit            tri_m, cont;
        logic [FW-1:0] klast;
        e.busy  = 0;
        e.done  = 0;
        e.valid = 0;
        e.fword = '0;
        e.k     = '0;
        d     = (v.dwell == 0) ? 1 : int'(v.dwell);
        n     = int'(v.n);
        tri_m = v.mode[1] && n > 0;
        cont  = v.mode[0];
        len   = tri_m ? 2 * n + 1 : n + 1;
        s     = (i - 1) / d;
        ph    = (i - 1) % d;
        if (v.abort_at > 0 && i > v.abort_at) return e;
        if (!cont && s >= len) begin
            if (s == len && ph == 0) begin
                e.done  = 1;
                klast   = tri_m ? '0 : FW'(v.n);
                e.fword = v.f_start + klast * v.f_step;
            end
            return e;
        end
        e.busy  = 1;
        e.valid = (i >= LAT + 1);
        if (s < len)     k = (tri_m && s > n) ? 2 * n - s : s;
        else if (!tri_m) k = s % (n + 1);
        else begin
            sp = (s - len) % (2 * n);
            k  = (sp < n) ? sp + 1 : 2 * n - 1 - sp;
        end
        e.k     = CW'(k);
        e.fword = v.f_start + FW'(k) * v.f_step;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " fword"},     64'(fword),     64'h0);
        check({tag, " pword"},     64'(pword),     64'h0);
        check({tag, " dds_en"},    64'(dds_en),    64'h0);
        check({tag, " busy"},      64'(busy),      64'h0);
        check({tag, " done"},      64'(done),      64'h0);
        check({tag, " out_valid"}, 64'(out_valid), 64'h0);
        check({tag, " step_idx"},  64'(step_idx),  64'h0);
    endtask

    task automatic drive_cfg(input vec_t v);
        f_start = v.f_start;
        f_step  = v.f_step;
        n_steps = v.n;
        dwell   = v.dwell;
        p_off   = v.p_off;
        mode    = v.mode;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t  e;
        int    done_seen;
        string c;
        done_seen = 0;
        @(negedge clk);
        drive_cfg(v);
        start = 1'b1;
        abort = 1'b0;
        for (int i = 1; i <= v.ncyc; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            e = model(v, i);
            c = $sformatf("%s c%0d", tag, i);
            check({c, " busy"},      64'(busy),      64'(e.busy));
            check({c, " dds_en"},    64'(dds_en),    64'(e.busy));
            check({c, " done"},      64'(done),      64'(e.done));
            check({c, " out_valid"}, 64'(out_valid), 64'(e.valid));
            if (e.busy) begin
                check({c, " fword"},    64'(fword),    64'(e.fword));
                check({c, " step_idx"}, 64'(step_idx), 64'(e.k));
                check({c, " pword"},    64'(pword),    64'(v.p_off));
            end
            if (e.done) check({c, " fword@done"}, 64'(fword), 64'(e.fword));
            if (done && done_seen == 0) done_seen = i;
            // Config changes after the accepted start must be ignored.
            f_start = $urandom;
            f_step  = $urandom;
            n_steps = CW'($urandom);
            dwell   = CW'($urandom);
            p_off   = PW'($urandom);
            mode    = 2'($urandom);
            if (i == v.abort_at)   abort = 1'b1;
            if (i == v.restart_at) start = 1'b1;
        end
        if (v.exp_done_at >= 0) check({tag, " done_cycle"}, 64'(done_seen), 64'(v.exp_done_at));
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        tbl[0] = '{32'h1000_0000, 32'h0100_0000, 16'd3, 16'd4, 11'h155, 2'b00, 20,  0, 0, 17};
        tbl[1] = '{32'h0000_1000, 32'h0000_0100, 16'd2, 16'd1, 11'h0AA, 2'b10,  9,  0, 0,  6};
        tbl[2] = '{32'hFFFF_FFF0, 32'h0000_0020, 16'd1, 16'd0, 11'h7FF, 2'b00,  5,  0, 0,  3};
        tbl[3] = '{32'h2000_0000, 32'h0000_0010, 16'd1, 16'd2, 11'h001, 2'b01, 14,  9, 0,  0};
        tbl[4] = '{32'h0000_0100, 32'h0000_0003, 16'd2, 16'd3, 11'h123, 2'b00, 12,  0, 4, 10};
        tbl[5] = '{32'h8000_0000, 32'h1000_0000, 16'd2, 16'd1, 11'h456, 2'b11, 16, 14, 0,  0};
        tbl[6] = '{32'h0ABC_DEF0, 32'h0000_0001, 16'd0, 16'd5, 11'h321, 2'b10,  8,  0, 0,  6};
        tbl[7] = '{32'h0000_0000, 32'h4000_0000, 16'd3, 16'd2, 11'h010, 2'b10,  9,  5, 0,  0};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        drive_cfg(tbl[0]);
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        for (int t = 0; t < 8; t++) run_vec(tbl[t], $sformatf("vec%0d", t));

        // start together with abort in IDLE must not begin a sweep
        @(negedge clk);
        drive_cfg(tbl[0]);
        start = 1'b1;
        abort = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            check($sformatf("start+abort c%0d busy", i),   64'(busy),   64'h0);
            check($sformatf("start+abort c%0d dds_en", i), 64'(dds_en), 64'h0);
            check($sformatf("start+abort c%0d done", i),   64'(done),   64'h0);
        end

        // asynchronous reset between edges mid-sweep, then a clean sweep afterwards
        @(negedge clk);
        drive_cfg(tbl[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'h1);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        run_vec(tbl[0], "post_rst");

        for (int r = 0; r < 25; r++) begin
            int d, len, bc;
            rv.f_start = $urandom;
            rv.f_step  = $urandom;
            rv.n       = CW'($urandom_range(0, 4));
            rv.dwell   = CW'($urandom_range(0, 3));
            rv.p_off   = PW'($urandom);
            rv.mode    = 2'($urandom_range(0, 3));
            rv.restart_at  = 0;
            rv.exp_done_at = -1;
            if (rv.mode[0]) begin
                rv.ncyc     = 30;
                rv.abort_at = $urandom_range(5, 28);
            end else begin
                d   = (rv.dwell == 0) ? 1 : int'(rv.dwell);
                len = (rv.mode[1] && rv.n != 0) ? 2 * int'(rv.n) + 1 : int'(rv.n) + 1;
                bc  = len * d;
                rv.ncyc     = bc + 3;
                rv.abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, bc) : 0;
                if (rv.abort_at == 0 && $urandom_range(0, 1) == 1) rv.restart_at = $urandom_range(1, bc);
            end
            run_vec(rv, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sequencer for the `dds_happen` tone generator. It latches a sweep configuration on `start`, then drives `fword`, `pword` and `en` into the DDS to produce stepped frequency sweeps: up-only or triangle, single-shot or continuous. It also reports when DDS output is valid. It sits between the register/command layer and `dds_happen` in the tracking transmit path.

## Interface
- `FW`, 32: frequency word width.
- `PW`, 11: phase word width.
- `CW`, 16: width of the step-count and dwell counters.
- `DDS_LAT`, 3: cycles from the DDS `en` rising to valid `dds_out` (accumulator, address register, ROM).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset. Integration inverts it for `dds_happen`, which uses active-low reset.
- `start`  in  1  one-cycle pulse; begins a sweep. Honoured only in IDLE.
- `abort`  in  1  level or pulse; stops any sweep.
- `f_start`  in  FW  first frequency word.
- `f_step`  in  FW  per-step increment (unsigned).
- `n_steps`  in  CW  last step index N; 0 means a single tone.
- `dwell`  in  CW  cycles per step; 0 is treated as 1.
- `p_off`  in  PW  phase offset, held for the whole sweep.
- `mode`  in  2  bit 0 = continuous, bit 1 = triangle.
- `fword`  out  FW  to the DDS.
- `pword`  out  PW  to the DDS.
- `dds_en`  out  1  to the DDS `en`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at normal completion.
- `out_valid`  out  1  DDS output settled and tracking the commanded word.
- `step_idx`  out  CW  current step index k.

## Operation
- All config inputs are latched on the accepted `start`; later changes are ignored until the next sweep.
- States:
  - IDLE: `dds_en`=0, `busy`=0.
  - UP: k counts 0..N.
  - DOWN: k counts N-1..0. Used only when triangle is set and N>0.
- Transitions:
  - IDLE→UP on `start`.
  - UP→DOWN at the end of step N when triangle is set and N>0.
  - UP, at the end of step N when triangle is clear: go to IDLE with `done`, or restart at k=0 when continuous is set.
  - DOWN, at the end of step 0: go to IDLE with `done`, or go to UP at k=1 when continuous is set. Step 0 is not repeated.
- `fword` = f_start + k·f_step, updated incrementally by ±f_step.
  - Arithmetic is modulo 2^FW; wrap-around is legal and not flagged.
  - On a continuous restart, `fword` reloads `f_start` exactly; there is no accumulated drift.
- Each step lasts D = max(`dwell`,1) cycles, counted by a down-counter.
- `pword` = latched `p_off` while busy.
- `abort` has priority over everything:
  - In the next cycle the block is in IDLE with `dds_en`=0 and `out_valid`=0.
  - `done` is not pulsed.
  - `start` and `abort` in the same cycle: the block stays idle.
- `start` while busy is ignored.
- Reset mid-sweep forces all outputs to their reset values immediately (asynchronous).

## Timing
- Reset values: `fword`=0, `pword`=0, `dds_en`=0, `busy`=0, `done`=0, `out_valid`=0, `step_idx`=0.
- All outputs are registered.
- With `start` sampled at edge t, from t+1: `busy`=1, `dds_en`=1, `fword`=f_start, k=0.
- Step k begins at t+1+k·D in UP.
- Single-shot up-only: `done`=1 for one cycle at t+1+(N+1)·D. In that same cycle `busy`=0, `dds_en`=0 and `fword` holds its last value.
- Single-shot triangle: `done` at t+1+(2N+1)·D.
- `out_valid` rises DDS_LAT cycles after `dds_en` rises and falls in the same cycle as `dds_en`. It stays high across step boundaries and continuous restarts.

## Structure
- Package `dds_pkg`:
  - state enum (IDLE, UP, DOWN);
  - `MODE_CONT`/`MODE_TRI` bit indices;
  - default `FW`/`PW`/`CW`/`DDS_LAT` constants, shared with `dds_happen` integration.
- One sub-module, `dds_dwell_timer`: loadable CW-bit down-counter that outputs a `step_end` pulse and treats 0 as 1.
- The FSM, word accumulator and valid delay line live in the top module.

## Test plan
- Basic up sweep: f_start=0x1000_0000, f_step=0x0100_0000, N=3, dwell=4, mode=00.
  - `fword` steps 0x10..0x13 (top byte), 4 cycles each.
  - `done` at t+17; `out_valid` high t+4..t+16.
- Triangle: N=2, dwell=1, mode=10.
  - `step_idx` sequence 0,1,2,1,0.
  - `done` at t+6.
- Wrap and zero dwell: f_start=0xFFFF_FFF0, f_step=0x20, N=1, dwell=0.
  - `fword` 0xFFFF_FFF0 then 0x0000_0010, 1 cycle each.
  - `done` at t+3.
- Continuous and abort: mode=01, N=1, dwell=2.
  - `fword` repeats f_start, f_start+step indefinitely.
  - `abort` at t+9 → at t+10 `dds_en`=0, `busy`=0, no `done`.
- Start collisions:
  - `start` while busy: no effect on the sequence.
  - `start` together with `abort` in IDLE: the block stays idle.
- Async reset mid-sweep: assert `rst` between edges → all outputs at reset values before the next edge. After release, a fresh `start` produces a correct sweep.
